// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store engine.
//   MASK_*  : access size encodings carried in mem_ctrl_maskMode (3 behaves as word)
//   state_t : bus transaction FSM encoding
package mem_access_unit_pkg;

    localparam int unsigned MASK_W = 2;

    localparam logic [MASK_W-1:0] MASK_BYTE = 2'd0;
    localparam logic [MASK_W-1:0] MASK_HALF = 2'd1;
    localparam logic [MASK_W-1:0] MASK_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Purely combinational byte-lane steering for the data-memory bus.
//   st_mask/st_addr_lo/store_data -> st_wdata (lane-replicated), st_wstrb (byte enables)
//   ld_mask/ld_addr_lo/ld_sext/ld_rdata -> ld_data (lane-extracted, sign/zero-extended)
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [MASK_W-1:0] st_mask,
    input  logic [1:0]        st_addr_lo,
    input  logic [31:0]       store_data,
    output logic [31:0]       st_wdata,
    output logic [3:0]        st_wstrb,
    input  logic [MASK_W-1:0] ld_mask,
    input  logic [1:0]        ld_addr_lo,
    input  logic              ld_sext,
    input  logic [31:0]       ld_rdata,
    output logic [31:0]       ld_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Store replication and strobe generation
    always_comb begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
        case (st_mask)
            MASK_BYTE: begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << st_addr_lo;
            end
            MASK_HALF: begin
                st_wdata = {2{store_data[15:0]}};
                st_wstrb = 4'b0011 << {st_addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        case (ld_addr_lo)
            2'd0:    byte_lane = ld_rdata[7:0];
            2'd1:    byte_lane = ld_rdata[15:8];
            2'd2:    byte_lane = ld_rdata[23:16];
            default: byte_lane = ld_rdata[31:24];
        endcase
        half_lane = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

        ld_data = ld_rdata;
        case (ld_mask)
            MASK_BYTE: ld_data = {{24{ld_sext & byte_lane[7]}}, byte_lane};
            MASK_HALF: ld_data = {{16{ld_sext & half_lane[15]}}, half_lane};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one req/ack bus transaction per access,
// pipeline stall until it completes, aligned/extended load data out.
//   clk, reset (async active-low)
//   mem_ctrl_*        : EX/MEM control bundle (read, write, size, sign-extend)
//   addr, store_data  : byte address and rs2 value
//   dmem_*            : data-memory bus (req held until ack)
//   mem_stall         : combinational hold for IF..EX/MEM
//   load_data/valid   : load result and its one-cycle update pulse
//   misalign          : combinational illegal-alignment flag
//   bus_err           : one-cycle pulse when a transaction times out
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_ctrl_memRead,
    input  logic              mem_ctrl_memWrite,
    input  logic [MASK_W-1:0] mem_ctrl_maskMode,
    input  logic              mem_ctrl_sext,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [31:0]       dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              mem_stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign,
    output logic              bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic [MASK_W-1:0] mask_q;
    logic              sext_q;
    logic [1:0]        addr_lo_q;

    logic        access;
    logic        accept;
    logic        timeout_hit;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;

    // Reserved size 3 falls into the word check through maskMode[1]
    assign access   = mem_ctrl_memRead | mem_ctrl_memWrite;
    assign misalign = access & (((mem_ctrl_maskMode == MASK_HALF) & addr[0]) |
                                (mem_ctrl_maskMode[1] & (|addr[1:0])));
    assign accept      = (state == IDLE) & access & ~misalign;
    assign mem_stall   = accept | (state == WAIT);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    mem_lane_align u_align (
        .st_mask    (mem_ctrl_maskMode),
        .st_addr_lo (addr[1:0]),
        .store_data (store_data),
        .st_wdata   (st_wdata),
        .st_wstrb   (st_wstrb),
        .ld_mask    (mask_q),
        .ld_addr_lo (addr_lo_q),
        .ld_sext    (sext_q),
        .ld_rdata   (dmem_rdata),
        .ld_data    (ld_data)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic; DONE always returns to IDLE without accepting
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = WAIT;
            WAIT:    if (dmem_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches, timeout counter and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            mask_q     <= '0;
            sext_q     <= 1'b0;
            addr_lo_q  <= '0;
            cnt        <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
            if (accept) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_ctrl_memWrite;
                dmem_addr  <= {addr[31:2], 2'b00};
                dmem_wdata <= st_wdata;
                dmem_wstrb <= mem_ctrl_memWrite ? st_wstrb : 4'b0000;
                mask_q     <= mem_ctrl_maskMode;
                sext_q     <= mem_ctrl_sext;
                addr_lo_q  <= addr[1:0];
                cnt        <= '0;
            end
            if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
                if (dmem_ack) begin
                    dmem_req <= 1'b0;
                    if (!dmem_we) begin
                        load_data  <= ld_data;
                        load_valid <= 1'b1;
                    end
                end else if (timeout_hit) begin
                    dmem_req <= 1'b0;
                    bus_err  <= 1'b1;
                end
            end
        end
    end

endmodule
